// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, FSM states, access sizes and
// instruction field positions.
package cpu_mc_pkg;

  localparam logic [5:0] OpNop  = 6'd0;
  localparam logic [5:0] OpAdd  = 6'd1;
  localparam logic [5:0] OpSub  = 6'd2;
  localparam logic [5:0] OpAnd  = 6'd3;
  localparam logic [5:0] OpOr   = 6'd4;
  localparam logic [5:0] OpXor  = 6'd5;
  localparam logic [5:0] OpAddi = 6'd6;
  localparam logic [5:0] OpLd   = 6'd7;
  localparam logic [5:0] OpSt   = 6'd8;
  localparam logic [5:0] OpBeqz = 6'd9;
  localparam logic [5:0] OpJmp  = 6'd10;
  localparam logic [5:0] OpHalt = 6'd63;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StFault
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor
  } alu_op_e;

  localparam logic [1:0] SizeWord  = 2'd2;
  localparam logic [1:0] SizeDword = 2'd3;

  localparam int unsigned OpLsb = 26;
  localparam int unsigned RdLsb = 21;
  localparam int unsigned RaLsb = 16;
  localparam int unsigned RbLsb = 11;
  localparam int unsigned ImmW  = 16;

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU for the multicycle core; produces the result and {V,C,N,Z} flags.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              carry;
  logic              ovf;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (alu_op_e'(op_i))
      AluAdd: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      AluSub: begin
        // Top bit of the widened difference is the borrow.
        sum   = {1'b0, a_i} - {1'b0, b_i};
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      AluAnd:  res = a_i & b_i;
      AluOr:   res = a_i | b_i;
      AluXor:  res = a_i ^ b_i;
      default: res = '0;
    endcase
    result_o = res;
    flags_o  = {ovf, carry, res[DATA_W-1], (res == '0)};
  end

endmodule

// File: rtl/cpu_core_mc.sv
// Multicycle CPU core: control FSM, register file and datapath with a ready handshake.
// Define CPU_WAIT_TIMEOUT_EN to abort accesses stalled for TIMEOUT cycles into FAULT.
module cpu_core_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DBG_W    = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [1:0]                  size,
  input  logic                        mem_ready,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DBG_W-1:0]            dbg_reg,
  output logic [3:0]                  status,
  output logic                        halted,
  output logic                        fault
);

  localparam int unsigned RegAw   = $clog2(NUM_REGS);
  localparam logic [1:0]  MemSize = (DATA_W == 64) ? SizeDword : SizeWord;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        status_q, status_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              rf_we;

  logic [5:0]        op;
  logic [RegAw-1:0]  rd_idx;
  logic [RegAw-1:0]  ra_idx;
  logic [RegAw-1:0]  rb_idx;
  logic [DATA_W-1:0] imm_ext;
  logic [ADDR_W-1:0] br_off;

  logic              is_alu;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  logic              in_req;
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] addr_int;
  logic [1:0]        size_int;
  logic [DATA_W-1:0] wdata_int;
  logic              wait_expired;
  logic              unused_ir;

  assign op      = ir_q[OpLsb +: 6];
  assign rd_idx  = ir_q[RdLsb +: RegAw];
  assign ra_idx  = ir_q[RaLsb +: RegAw];
  assign rb_idx  = ir_q[RbLsb +: RegAw];
  assign imm_ext = {{(DATA_W-ImmW){ir_q[ImmW-1]}}, ir_q[ImmW-1:0]};
  assign br_off  = {imm_ext[ADDR_W-3:0], 2'b00};
  assign unused_ir = ^ir_q;

  always_comb begin
    is_alu = 1'b1;
    alu_op = AluAdd;
    alu_b  = b_q;
    case (op)
      OpAdd:   alu_op = AluAdd;
      OpSub:   alu_op = AluSub;
      OpAnd:   alu_op = AluAnd;
      OpOr:    alu_op = AluOr;
      OpXor:   alu_op = AluXor;
      OpAddi:  alu_b  = imm_ext;
      default: is_alu = 1'b0;
    endcase
  end

  cpu_mc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign in_req = (state_q == StFetch) || (state_q == StMem);

`ifdef CPU_WAIT_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;

  // Restarts from zero whenever an access completes or no access is pending.
  always_comb begin
    wait_d = '0;
    if (in_req && !mem_ready) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  assign wait_expired = in_req && !mem_ready && (wait_q == WaitW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0) & in_req;
  assign wait_expired   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    ea_d      = ea_q;
    res_d     = res_q;
    status_d  = status_q;
    rf_we     = 1'b0;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    addr_int  = '0;
    size_int  = '0;
    wdata_int = '0;
    unique case (state_q)
      StFetch: begin
        addr_int = pc_q;
        size_int = SizeWord;
        req_rd   = 1'b1;
        if (mem_ready) begin
          ir_d    = rdata[31:0];
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        a_d     = regs_q[ra_idx];
        b_d     = regs_q[rb_idx];
        state_d = StExec;
      end
      StExec: begin
        if (is_alu) begin
          res_d    = alu_res;
          status_d = alu_flags;
          state_d  = StWb;
        end else begin
          case (op)
            OpLd, OpSt: begin
              ea_d    = a_q[ADDR_W-1:0] + imm_ext[ADDR_W-1:0];
              state_d = StMem;
            end
            // pc already points past the branch, so the offset is relative to pc+4.
            OpBeqz: begin
              if (a_q == '0) begin
                pc_d = pc_q + br_off;
              end
              state_d = StFetch;
            end
            OpJmp: begin
              pc_d    = a_q[ADDR_W-1:0];
              state_d = StFetch;
            end
            OpHalt:  state_d = StHalt;
            OpNop:   state_d = StFetch;
            default: state_d = StFetch;
          endcase
        end
      end
      StMem: begin
        addr_int = ea_q;
        size_int = MemSize;
        if (op == OpSt) begin
          req_wr    = 1'b1;
          wdata_int = regs_q[rd_idx];
        end else begin
          req_rd = 1'b1;
        end
        if (mem_ready) begin
          if (op == OpSt) begin
            state_d = StFetch;
          end else begin
            res_d   = rdata;
            state_d = StWb;
          end
        end else if (wait_expired) begin
          state_d = StFault;
        end
      end
      StWb: begin
        rf_we   = (rd_idx != '0);
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      ea_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      status_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ea_q     <= ea_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      status_q <= status_d;
      if (rf_we) begin
        regs_q[rd_idx] <= res_q;
      end
    end
  end

  // Requests are masked while reset is held so an interrupted access drops immediately.
  assign mem_read  = req_rd & ~reset;
  assign mem_write = req_wr & ~reset;
  assign address   = reset ? '0 : addr_int;
  assign size      = reset ? '0 : size_int;
  assign wdata     = reset ? '0 : wdata_int;
  assign status    = status_q;
  assign dbg_reg   = regs_q[dbg_sel][DBG_W-1:0];
  assign halted    = (state_q == StHalt) || (state_q == StFault);
`ifdef CPU_WAIT_TIMEOUT_EN
  assign fault     = (state_q == StFault);
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
Parametrised multicycle CPU core. It is the successor to the fixed 64-bit control-unit/datapath top with eight hardwired 16-bit register taps.
- Control FSM and datapath live in one block; data width and register count are generalised.
- The shared inout data bus is split into separate read and write buses.
- Adds a memory ready handshake (wait states) and a selectable debug register port.
- Sits between the testbench/SoC memory model and the system top.

Parameters:
DATA_W, 64, datapath and register width (32 or 64)
ADDR_W, 32, memory byte-address width
NUM_REGS, 8, architectural registers (power of 2, 2..32); r0 reads zero
DBG_W, 16, width of debug register tap (≤ DATA_W; low bits of selected register)
TIMEOUT, 255, ready-wait limit when CPU_WAIT_TIMEOUT_EN defined

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
address  out  ADDR_W  memory byte address
wdata  out  DATA_W  store data
rdata  in  DATA_W  fetch/load data; low 32 bits carry instructions
mem_read  out  1  read request, held until mem_ready
mem_write  out  1  write request, held until mem_ready
size  out  2  access size: 0=byte, 1=half, 2=word32, 3=dword
mem_ready  in  1  completes the current access in the cycle it is high
dbg_sel  in  $clog2(NUM_REGS)  debug register select
dbg_reg  out  DBG_W  combinational low DBG_W bits of register[dbg_sel]
status  out  4  flags {V,C,N,Z} from last ALU op
halted  out  1  high in HALT (and FAULT) state
fault  out  1  high in FAULT state only

Behaviour:
- Reset: pc=0, all registers 0, status=0, ir=0, state FETCH. mem_read, mem_write, halted and fault are 0; address=0, wdata=0, size=0.
- Reset during an access wins on the next edge: the request drops, no register or memory side effect.
- Instruction format, 32 bits: op[31:26] rd[25:21] ra[20:16] rb[15:11] imm[15:0]. imm is sign-extended to DATA_W.
- Register indices are taken modulo NUM_REGS.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI, 7 LD, 8 ST, 9 BEQZ, 10 JMP, 63 HALT. Any other opcode is a NOP.
- FSM states:
  - FETCH: address=pc, mem_read=1, size=2. On mem_ready: ir<=rdata[31:0], pc<=pc+4, go to DECODE.
  - DECODE: latch A=reg[ra], B=reg[rb]. Go to EXEC.
  - EXEC:
    - ALU ops update status and go to WB.
    - LD/ST compute ea=A+imm and go to MEM.
    - BEQZ: if A==0, pc<=pc+4+(imm<<2)... specifically pc<=pc+(imm<<2), relative to the already-incremented pc; then FETCH.
    - JMP: pc<=A, then FETCH.
    - HALT goes to HALT; NOP goes to FETCH.
  - MEM:
    - address=ea, size=3 (dword when DATA_W=64, otherwise 2).
    - LD asserts mem_read; ST asserts mem_write with wdata=reg[rd].
    - On mem_ready: LD goes to WB with rdata latched; ST goes to FETCH.
  - WB: reg[rd]<=result unless rd==0. Go to FETCH.
  - HALT: absorbing; only reset exits. All requests are 0.
- Latency with mem_ready tied high:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST and branch: 4 and 3 cycles respectively.
  - Each wait cycle adds 1.
- Arithmetic: modulo 2^DATA_W.
  - C = carry out for ADD, borrow for SUB.
  - V = signed overflow.
  - N = msb of result; Z = result==0.
  - Logic ops clear C and V.
- Address and request outputs are registered-stable for the whole wait period. pc wraps modulo 2^ADDR_W.

Optional Feature:
CPU_WAIT_TIMEOUT_EN
- Defined:
  - A wait counter resets at each new request.
  - If mem_ready is still low after TIMEOUT cycles, the access aborts and the FSM enters FAULT.
  - FAULT drives fault=1, halted=1, no requests, and is absorbing until reset.
- Undefined: waits indefinitely; the FAULT state and counter are absent; fault is tied to 0.

Decomposition:
- Package cpu_mc_pkg holds:
  - opcode localparams
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT)
  - size codes
  - instruction field bit positions
- One sub-module, cpu_mc_alu: combinational, DATA_W-parametrised, computing result and {V,C,N,Z}.
- Register file and FSM stay in cpu_core_mc.

Test Plan:
- ADDI r1,r0,5; ADD r2,r1,r1, with mem_ready=1 -> r2=10 via dbg_sel=2; second instruction retires 4 cycles after the first; status Z=0.
- SUB r3,r1,r1 with r1=5 -> r3=0, status Z=1, C=0. ADD 0x7FFF...F+1 -> V=1, N=1.
- LD r4,8(r0) with mem_ready delayed 3 cycles and rdata=0xDEAD_BEEF_0000_0001 -> address=8 and mem_read held 4 cycles; r4 equals that value.
- ST r4,16(r0) -> one cycle with mem_write=1, address=16, wdata=r4, size=3.
- BEQZ r0,+2 at pc=0 -> next fetch address=12. Then HALT -> halted=1, no further mem_read.
- Reset asserted mid-LD wait -> next cycle mem_read=0, pc=0, r4 unchanged=0. Also, with CPU_WAIT_TIMEOUT_EN and TIMEOUT=4 and mem_ready held low -> fault=1 after 4 wait cycles.
